// File: rtl/ama_riscv_rf_wb_arbiter.sv
// Register-file write-port owner: arbitrates pipeline (wb0) and long-latency (wb1)
// writebacks, tracks long-latency destinations in a busy scoreboard, stalls decode.
module ama_riscv_rf_wb_arbiter #(
  parameter int MAX_WAIT = 4,
  parameter int CNT_W    = $clog2(MAX_WAIT + 1),
  parameter int ARCH_W   = 32,
  parameter int RF_AW    = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_iss_valid,
  output logic              o_iss_ready,
  input  logic [RF_AW-1:0]  i_iss_rd,
  input  logic              i_iss_pair,
  input  logic              i_wb0_valid,
  output logic              o_wb0_ready,
  input  logic [RF_AW-1:0]  i_wb0_rd,
  input  logic              i_wb0_pair,
  input  logic [ARCH_W-1:0] i_wb0_data,
  input  logic [ARCH_W-1:0] i_wb0_data_p,
  input  logic              i_wb1_valid,
  output logic              o_wb1_ready,
  input  logic [RF_AW-1:0]  i_wb1_rd,
  input  logic              i_wb1_pair,
  input  logic [ARCH_W-1:0] i_wb1_data,
  input  logic [ARCH_W-1:0] i_wb1_data_p,
  input  logic [RF_AW-1:0]  i_rs1_addr,
  input  logic [RF_AW-1:0]  i_rs2_addr,
  output logic              o_hz_stall,
  output logic              o_rf_we,
  output logic              o_rf_we_p,
  output logic [RF_AW-1:0]  o_rf_addr_d,
  output logic [ARCH_W-1:0] o_rf_data_d,
  output logic [ARCH_W-1:0] o_rf_data_dp
);

  localparam int RF_NUM = 1 << RF_AW;
  localparam logic [RF_AW-1:0] X0  = '0;
  localparam logic [RF_AW-1:0] X31 = '1;

  function automatic logic [RF_AW-1:0] get_rdp(input logic [RF_AW-1:0] rd);
    return rd + {{(RF_AW-1){1'b0}}, 1'b1};
  endfunction

  logic [CNT_W-1:0]  r_cnt;
  logic [RF_NUM-1:0] r_busy;
  logic              r_clr_valid;
  logic [RF_AW-1:0]  r_clr_rd;
  logic              r_clr_pair;
  logic              r_we;
  logic              r_we_p;
  logic [RF_AW-1:0]  r_addr;
  logic [ARCH_W-1:0] r_data;
  logic [ARCH_W-1:0] r_data_p;

  logic              w_force;
  logic              w_acc0;
  logic              w_acc1;
  logic              w_acc;
  logic              w_iss_acc;
  logic [RF_AW-1:0]  w_sel_rd;
  logic              w_sel_pair;
  logic [ARCH_W-1:0] w_sel_data;
  logic [ARCH_W-1:0] w_sel_data_p;
  logic [RF_NUM-1:0] w_set;
  logic [RF_NUM-1:0] w_clr;

  // wb0 normally wins; a wb1 refused MAX_WAIT times in a row takes the port
  assign w_force     = i_wb1_valid && (r_cnt == CNT_W'(MAX_WAIT));
  assign o_wb0_ready = !w_force;
  assign o_wb1_ready = w_force || !i_wb0_valid;
  assign w_acc0      = i_wb0_valid && o_wb0_ready;
  assign w_acc1      = i_wb1_valid && o_wb1_ready;
  assign w_acc       = w_acc0 || w_acc1;

  assign w_sel_rd     = w_acc1 ? i_wb1_rd     : i_wb0_rd;
  assign w_sel_pair   = w_acc1 ? i_wb1_pair   : i_wb0_pair;
  assign w_sel_data   = w_acc1 ? i_wb1_data   : i_wb0_data;
  assign w_sel_data_p = w_acc1 ? i_wb1_data_p : i_wb0_data_p;

  assign o_iss_ready = !r_busy[i_iss_rd] && !(i_iss_pair && r_busy[get_rdp(i_iss_rd)]);
  assign w_iss_acc   = i_iss_valid && o_iss_ready;
  assign o_hz_stall  = r_busy[i_rs1_addr] || r_busy[i_rs2_addr];

  always_comb begin
    w_set = '0;
    w_clr = '0;
    if (w_iss_acc && (i_iss_rd != X0)) begin
      w_set[i_iss_rd] = 1'b1;
      if (i_iss_pair) w_set[get_rdp(i_iss_rd)] = 1'b1;
    end
    if (r_clr_valid) begin
      w_clr[r_clr_rd] = 1'b1;
      if (r_clr_pair) w_clr[get_rdp(r_clr_rd)] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_busy      <= '0;
      r_clr_valid <= 1'b0;
      r_clr_rd    <= '0;
      r_clr_pair  <= 1'b0;
      r_we        <= 1'b0;
      r_we_p      <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_data_p    <= '0;
    end else begin
      if (!i_wb1_valid || w_acc1) r_cnt <= '0;
      else if (r_cnt != CNT_W'(MAX_WAIT)) r_cnt <= r_cnt + CNT_W'(1);

      // set wins over clear; x0 is never busy
      r_busy <= ((r_busy & ~w_clr) | w_set) & ~{{(RF_NUM-1){1'b0}}, 1'b1};

      // busy clears on the edge where the wb1 result actually lands
      r_clr_valid <= w_acc1;
      r_clr_rd    <= i_wb1_rd;
      r_clr_pair  <= i_wb1_pair;

      r_we   <= w_acc && (w_sel_rd != X0);
      r_we_p <= w_acc && (w_sel_rd != X0) && w_sel_pair && (w_sel_rd != X31);
      if (w_acc) begin
        r_addr   <= w_sel_rd;
        r_data   <= w_sel_data;
        r_data_p <= w_sel_data_p;
      end
    end
  end

`ifndef SYNT
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (w_acc && w_sel_pair && (w_sel_rd == X31))
        $fatal(1, "rf_wb_arbiter: paired write with rd=x31");
      if (w_acc1 && !r_busy[i_wb1_rd])
        $error("rf_wb_arbiter: wb1 writes rd=%0d which is not busy", i_wb1_rd);
    end
  end
`endif

  assign o_rf_we      = r_we;
  assign o_rf_we_p    = r_we_p;
  assign o_rf_addr_d  = r_addr;
  assign o_rf_data_d  = r_data;
  assign o_rf_data_dp = r_data_p;

endmodule

// File: tb/tb_ama_riscv_rf_wb_arbiter.sv
// Directed plus randomized bench for the RF writeback arbiter, checked against a
// set-based scoreboard model and a refusal-count arbitration model.
module tb_ama_riscv_rf_wb_arbiter;
  localparam int MAX_WAIT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        iss_valid, iss_pair, iss_ready;
  logic [4:0]  iss_rd;
  logic        wb0_valid, wb0_pair, wb0_ready;
  logic [4:0]  wb0_rd;
  logic [31:0] wb0_data, wb0_data_p;
  logic        wb1_valid, wb1_pair, wb1_ready;
  logic [4:0]  wb1_rd;
  logic [31:0] wb1_data, wb1_data_p;
  logic [4:0]  rs1, rs2;
  logic        hz_stall, rf_we, rf_we_p;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data, rf_data_p;

  ama_riscv_rf_wb_arbiter #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .rst(rst),
    .i_iss_valid(iss_valid), .o_iss_ready(iss_ready), .i_iss_rd(iss_rd), .i_iss_pair(iss_pair),
    .i_wb0_valid(wb0_valid), .o_wb0_ready(wb0_ready), .i_wb0_rd(wb0_rd), .i_wb0_pair(wb0_pair),
    .i_wb0_data(wb0_data), .i_wb0_data_p(wb0_data_p),
    .i_wb1_valid(wb1_valid), .o_wb1_ready(wb1_ready), .i_wb1_rd(wb1_rd), .i_wb1_pair(wb1_pair),
    .i_wb1_data(wb1_data), .i_wb1_data_p(wb1_data_p),
    .i_rs1_addr(rs1), .i_rs2_addr(rs2), .o_hz_stall(hz_stall),
    .o_rf_we(rf_we), .o_rf_we_p(rf_we_p), .o_rf_addr_d(rf_addr),
    .o_rf_data_d(rf_data), .o_rf_data_dp(rf_data_p)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // reference model state
  bit          m_busy[32];
  int          m_refused;
  bit          m_pend;
  int          m_pend_rd;
  bit          m_pend_pair;
  logic        e_we, e_we_p;
  logic [4:0]  e_addr;
  logic [31:0] e_data, e_data_p;
  bit          last_acc0, last_acc1, last_iss_acc;

  typedef struct { logic [4:0] rd; logic pair; } op_t;
  op_t outstanding[$];

  function automatic int rdp(input int rd);
    return (rd + 1) % 32;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 32; i++) m_busy[i] = 1'b0;
    m_refused = 0;
    m_pend    = 1'b0;
    e_we = 1'b0; e_we_p = 1'b0; e_addr = '0; e_data = '0; e_data_p = '0;
  endtask

  task automatic check_rf();
    chk("rf_we", rf_we, e_we);
    chk("rf_we_p", rf_we_p, e_we_p);
    chk("rf_addr", rf_addr, e_addr);
    chk("rf_data", rf_data, e_data);
    chk("rf_data_p", rf_data_p, e_data_p);
  endtask

  // One clock: check combinational outputs, take the edge, check registered outputs.
  task automatic step();
    bit ir, wb1_wins, r0, r1, a0, a1, iacc;
    int rd;
    #1;
    ir       = !(m_busy[iss_rd] || (iss_pair && m_busy[rdp(iss_rd)]));
    wb1_wins = wb1_valid && (!wb0_valid || m_refused >= MAX_WAIT);
    r0       = !(wb1_valid && m_refused >= MAX_WAIT);
    r1       = wb1_valid ? wb1_wins : !wb0_valid;
    a0       = wb0_valid && !wb1_wins;
    a1       = wb1_wins;
    chk("iss_ready", iss_ready, ir);
    chk("wb0_ready", wb0_ready, r0);
    chk("wb1_ready", wb1_ready, r1);
    chk("hz_stall", hz_stall, m_busy[rs1] || m_busy[rs2]);
    iacc = iss_valid && ir;
    @(posedge clk);
    #1;
    if (rst) begin
      model_reset();
      a0 = 1'b0; a1 = 1'b0; iacc = 1'b0;
    end else begin
      if (m_pend) begin
        m_busy[m_pend_rd] = 1'b0;
        if (m_pend_pair) m_busy[rdp(m_pend_rd)] = 1'b0;
      end
      if (iacc && iss_rd != 0) begin
        m_busy[iss_rd] = 1'b1;
        if (iss_pair) m_busy[rdp(iss_rd)] = 1'b1;
      end
      m_busy[0]   = 1'b0;
      m_pend      = a1;
      m_pend_rd   = wb1_rd;
      m_pend_pair = wb1_pair;
      if (a0 || a1) begin
        rd       = a1 ? wb1_rd : wb0_rd;
        e_we     = (rd != 0);
        e_we_p   = e_we && (a1 ? wb1_pair : wb0_pair);
        e_addr   = rd[4:0];
        e_data   = a1 ? wb1_data : wb0_data;
        e_data_p = a1 ? wb1_data_p : wb0_data_p;
      end else begin
        e_we = 1'b0; e_we_p = 1'b0;
      end
      if (wb1_valid && !a1) m_refused = (m_refused < MAX_WAIT) ? m_refused + 1 : MAX_WAIT;
      else m_refused = 0;
    end
    last_acc0 = a0; last_acc1 = a1; last_iss_acc = iacc;
    check_rf();
    $display("cyc t=%0t rst=%0b iss=%0b/%0d wb0=%0b/%0d wb1=%0b/%0d -> we=%0b we_p=%0b addr=%0d hz=%0b",
             $time, rst, iacc, iss_rd, a0, wb0_rd, a1, wb1_rd, rf_we, rf_we_p, rf_addr, hz_stall);
  endtask

  task automatic idle();
    iss_valid = 0; iss_pair = 0; iss_rd = 0;
    wb0_valid = 0; wb0_pair = 0; wb0_rd = 0; wb0_data = 0; wb0_data_p = 0;
    wb1_valid = 0; wb1_pair = 0; wb1_rd = 0; wb1_data = 0; wb1_data_p = 0;
    rs1 = 0; rs2 = 0;
  endtask

  initial begin
    int win;
    idle();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    check_rf();
    chk("reset_hz", hz_stall, 1'b0);
    rst = 1'b0;

    // 1) lone wb0 write
    wb0_valid = 1; wb0_rd = 5; wb0_data = 32'hDEAD_BEEF; wb0_data_p = 32'h1111_2222;
    step();
    chk("t1_wb0_acc", last_acc0, 1'b1);
    idle(); step();

    // 2) paired issue, hazard, blocked reissue, paired wb1 clears busy
    iss_valid = 1; iss_rd = 8; iss_pair = 1; step();
    idle(); rs1 = 9; iss_valid = 1; iss_rd = 9; step();
    chk("t2_reissue_blocked", last_iss_acc, 1'b0);
    idle(); rs1 = 9;
    wb1_valid = 1; wb1_rd = 8; wb1_pair = 1; wb1_data = 32'hA5A5_0008; wb1_data_p = 32'h5A5A_0009;
    step();
    idle(); rs1 = 9; step();
    idle(); rs1 = 9; step();
    chk("t2_stall_cleared", hz_stall, 1'b0);

    // 3) contention: wb0 wins MAX_WAIT times, then wb1 is forced through
    iss_valid = 1; iss_rd = 20; step();
    idle();
    win = -1;
    for (int i = 0; i < MAX_WAIT + 2; i++) begin
      wb0_valid = 1; wb0_rd = 3; wb0_data = 32'h100 + i;
      wb1_valid = 1; wb1_rd = 20; wb1_data = 32'hCAFE_0000 + i;
      step();
      if (last_acc1) begin win = i; break; end
    end
    chk("t3_wb1_win_cycle", win, MAX_WAIT);
    idle(); step();

    // 4) x0 writes and issues are inert
    wb0_valid = 1; wb0_rd = 0; wb0_data = 32'h1234; step();
    chk("t4_x0_we", rf_we, 1'b0);
    idle(); iss_valid = 1; iss_rd = 0; step();
    idle(); iss_valid = 1; iss_rd = 0; rs1 = 0; step();

    // 5) reset right after a wb1 accept drops the pending result
    idle(); iss_valid = 1; iss_rd = 12; iss_pair = 1; step();
    idle(); wb1_valid = 1; wb1_rd = 12; wb1_pair = 1; wb1_data = 32'h77; step();
    idle(); rst = 1; rs1 = 13; step();
    rst = 0; rs1 = 12; rs2 = 13; step();
    chk("t5_hz_after_rst", hz_stall, 1'b0);

    // randomized traffic
    idle();
    outstanding.delete();
    for (int c = 0; c < 500; c++) begin
      iss_valid = ($urandom_range(0, 2) == 0);
      iss_rd    = 5'($urandom_range(1, 31));
      iss_pair  = (iss_rd != 31) && ($urandom_range(0, 1) == 1);
      wb0_valid = ($urandom_range(0, 1) == 1);
      wb0_rd    = 5'($urandom_range(0, 31));
      wb0_pair  = (wb0_rd != 31) && ($urandom_range(0, 1) == 1);
      wb0_data  = $urandom; wb0_data_p = $urandom;
      if (!wb1_valid && outstanding.size() > 0 && $urandom_range(0, 1) == 1) begin
        wb1_valid  = 1;
        wb1_rd     = outstanding[0].rd;
        wb1_pair   = outstanding[0].pair;
        wb1_data   = $urandom;
        wb1_data_p = $urandom;
      end
      rs1 = 5'($urandom_range(0, 31));
      rs2 = 5'($urandom_range(0, 31));
      step();
      if (last_iss_acc) outstanding.push_back('{rd: iss_rd, pair: iss_pair});
      if (last_acc1) begin
        void'(outstanding.pop_front());
        wb1_valid = 0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
